// File: rtl/rwlri_seq_driver.sv
// Command sequencer for a loadable, incrementing register: expands one CLR/LOAD/INCN/LOAD_INCN
// command into non-overlapping clear/load/increment strobes and tracks the expected register value.
module rwlri_seq_driver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_CNT,
  output logic             REG_RST,
  output logic             REG_WE,
  output logic             REG_INC,
  output logic [WIDTH-1:0] REG_DATA,
  output logic [WIDTH-1:0] SHADOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] OP_CLR       = 2'b00;
  localparam logic [1:0] OP_LOAD      = 2'b01;
  localparam logic [1:0] OP_INCN      = 2'b10;
  localparam logic [1:0] OP_LOAD_INCN = 2'b11;

  typedef enum logic [2:0] {IDLE, CLR, LOAD, INC, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;

  // The state names the phase whose strobe is visible now, so each edge registers the
  // strobe and post-strobe shadow value of the phase being entered.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      CMD_READY <= 1'b1;
      REG_RST   <= 1'b0;
      REG_WE    <= 1'b0;
      REG_INC   <= 1'b0;
      REG_DATA  <= '0;
      SHADOW    <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      remaining <= '0;
    end else begin
      REG_RST <= 1'b0;
      REG_WE  <= 1'b0;
      REG_INC <= 1'b0;
      DONE    <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            case (CMD_OP)
              OP_CLR: begin
                state     <= CLR;
                REG_RST   <= 1'b1;
                SHADOW    <= '0;
                remaining <= '0;
              end
              OP_LOAD, OP_LOAD_INCN: begin
                state     <= LOAD;
                REG_WE    <= 1'b1;
                REG_DATA  <= CMD_DATA;
                SHADOW    <= CMD_DATA;
                remaining <= (CMD_OP == OP_LOAD_INCN) ? CMD_CNT : '0;
              end
              default: begin
                if (CMD_CNT != '0) begin
                  state     <= INC;
                  REG_INC   <= 1'b1;
                  SHADOW    <= SHADOW + WIDTH'(1);
                  remaining <= CMD_CNT;
                end else begin
                  state     <= FIN;
                  DONE      <= 1'b1;
                  remaining <= '0;
                end
              end
            endcase
          end
        end
        CLR: begin
          state <= FIN;
          DONE  <= 1'b1;
        end
        LOAD: begin
          if (remaining != '0) begin
            state   <= INC;
            REG_INC <= 1'b1;
            SHADOW  <= SHADOW + WIDTH'(1);
          end else begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end
        INC: begin
          // remaining counts the increment currently on the bus, so 1 means this was the last
          if (remaining == CNT_W'(1)) begin
            state     <= FIN;
            DONE      <= 1'b1;
            remaining <= '0;
          end else begin
            REG_INC   <= 1'b1;
            SHADOW    <= SHADOW + WIDTH'(1);
            remaining <= remaining - CNT_W'(1);
          end
        end
        FIN: begin
          state     <= IDLE;
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
          remaining <= '0;
        end
        default: begin
          state     <= IDLE;
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rwlri_seq_driver.sv
// Self-checking bench for rwlri_seq_driver: directed scenarios plus random commands,
// compared every cycle against a queue-based model of the expected output sequence.
module tb_rwlri_seq_driver;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             RST;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [WIDTH-1:0] CMD_DATA;
  logic [CNT_W-1:0] CMD_CNT;
  logic             REG_RST;
  logic             REG_WE;
  logic             REG_INC;
  logic [WIDTH-1:0] REG_DATA;
  logic [WIDTH-1:0] SHADOW;
  logic             BUSY;
  logic             DONE;

  rwlri_seq_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_CNT(CMD_CNT),
    .REG_RST(REG_RST), .REG_WE(REG_WE), .REG_INC(REG_INC),
    .REG_DATA(REG_DATA), .SHADOW(SHADOW), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic             we;
    logic             inc;
    logic             busy;
    logic             done;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] shadow;
  } exp_t;

  exp_t             cur;
  exp_t             q[$];
  logic [WIDTH-1:0] mShadow;
  logic [WIDTH-1:0] mRegData;
  logic             hs;
  int               checks   = 0;
  int               failures = 0;

  function automatic exp_t idleExp();
    exp_t e = '0;
    e.ready  = 1'b1;
    e.data   = mRegData;
    e.shadow = mShadow;
    return e;
  endfunction

  function automatic exp_t busyExp();
    exp_t e = '0;
    e.busy   = 1'b1;
    e.data   = mRegData;
    e.shadow = mShadow;
    return e;
  endfunction

  // A command is expanded up front into the list of per-cycle outputs it must produce
  task automatic buildSequence(input logic [1:0] op, input logic [WIDTH-1:0] d,
                               input logic [CNT_W-1:0] n);
    exp_t e;
    if (op == 2'd0) begin
      mShadow = '0;
      e = busyExp(); e.rst = 1'b1; q.push_back(e);
    end
    if (op == 2'd1 || op == 2'd3) begin
      mShadow  = d;
      mRegData = d;
      e = busyExp(); e.we = 1'b1; q.push_back(e);
    end
    if (op == 2'd2 || op == 2'd3) begin
      for (int i = 0; i < int'(n); i++) begin
        mShadow = mShadow + 16'd1;
        e = busyExp(); e.inc = 1'b1; q.push_back(e);
      end
    end
    e = busyExp(); e.done = 1'b1; q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("REG_RST",   32'(REG_RST),   32'(cur.rst));
    checkOutput("REG_WE",    32'(REG_WE),    32'(cur.we));
    checkOutput("REG_INC",   32'(REG_INC),   32'(cur.inc));
    checkOutput("REG_DATA",  32'(REG_DATA),  32'(cur.data));
    checkOutput("SHADOW",    32'(SHADOW),    32'(cur.shadow));
    checkOutput("BUSY",      32'(BUSY),      32'(cur.busy));
    checkOutput("DONE",      32'(DONE),      32'(cur.done));
    checkOutput("CMD_READY", 32'(CMD_READY), 32'(cur.ready));
    checkOutput("strobe_onehot0", 32'($onehot0({REG_RST, REG_WE, REG_INC})), 32'd1);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] d,
                               input logic [CNT_W-1:0] n, input logic r);
    @(negedge clk);
    CMD_VALID = v;
    CMD_OP    = op;
    CMD_DATA  = d;
    CMD_CNT   = n;
    RST       = r;
    hs = !r && v && cur.ready;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      mShadow  = '0;
      mRegData = '0;
      cur = idleExp();
    end else begin
      if (hs) buildSequence(op, d, n);
      if (q.size() > 0) cur = q.pop_front();
      else cur = idleExp();
    end
    compareAll();
  endtask

  logic [WIDTH-1:0] expShadows [4];
  int               busyCount;
  int               acceptIdx;
  logic             rv;
  logic             vv;
  logic [1:0]       opv;
  logic [CNT_W-1:0] nv;

  initial begin
    cur       = '0;
    mShadow   = '0;
    mRegData  = '0;
    hs        = 1'b0;
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP    = 2'd0;
    CMD_DATA  = '0;
    CMD_CNT   = '0;

    // Reset state
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b1);
    applyStimulus(1'b1, 2'd1, 16'h5555, 8'd0, 1'b1);
    checkOutput("reset_ready",  32'(CMD_READY), 32'd1);
    checkOutput("reset_shadow", 32'(SHADOW),    32'h0);
    checkOutput("reset_busy",   32'(BUSY),      32'd0);
    checkOutput("reset_data",   32'(REG_DATA),  32'h0);

    // LOAD 0x1234
    applyStimulus(1'b1, 2'd1, 16'h1234, 8'd0, 1'b0);
    checkOutput("load_we",     32'(REG_WE),   32'd1);
    checkOutput("load_data",   32'(REG_DATA), 32'h1234);
    checkOutput("load_shadow", 32'(SHADOW),   32'h1234);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("load_done", 32'(DONE), 32'd1);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("load_ready_after", 32'(CMD_READY), 32'd1);

    // LOAD_INCN 0xFFFE x3 wraps through zero
    expShadows[0] = 16'hFFFE;
    expShadows[1] = 16'hFFFF;
    expShadows[2] = 16'h0000;
    expShadows[3] = 16'h0001;
    busyCount = 0;
    applyStimulus(1'b1, 2'd3, 16'hFFFE, 8'd3, 1'b0);
    busyCount += int'(BUSY);
    checkOutput("ldinc_shadow0", 32'(SHADOW), 32'(expShadows[0]));
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
      busyCount += int'(BUSY);
      checkOutput("ldinc_inc",    32'(REG_INC), 32'd1);
      checkOutput("ldinc_shadow", 32'(SHADOW),  32'(expShadows[i]));
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
      busyCount += int'(BUSY);
    end
    checkOutput("ldinc_busy_window", 32'(busyCount), 32'd5);

    // INCN with CNT=0 leaves SHADOW untouched
    applyStimulus(1'b1, 2'd1, 16'h0042, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'd2, 16'h0, 8'd0, 1'b0);
    checkOutput("inc0_done",   32'(DONE),   32'd1);
    checkOutput("inc0_shadow", 32'(SHADOW), 32'h0042);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);

    // CLR after 0xABCD
    applyStimulus(1'b1, 2'd1, 16'hABCD, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    applyStimulus(1'b1, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("clr_strobe", 32'(REG_RST), 32'd1);
    checkOutput("clr_shadow", 32'(SHADOW),  32'h0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("clr_done",   32'(DONE),    32'd1);
    checkOutput("clr_single", 32'(REG_RST), 32'd0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);

    // INCN 10 aborted by RST after 4 increments
    applyStimulus(1'b1, 2'd2, 16'h0, 8'd10, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("abort_pre_shadow", 32'(SHADOW), 32'h4);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b1);
    checkOutput("abort_inc",    32'(REG_INC),   32'd0);
    checkOutput("abort_shadow", 32'(SHADOW),    32'h0);
    checkOutput("abort_ready",  32'(CMD_READY), 32'd1);
    checkOutput("abort_busy",   32'(BUSY),      32'd0);
    applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("abort_no_done", 32'(DONE), 32'd0);

    // CMD_VALID held high: LOAD 5 then INCN 2
    applyStimulus(1'b1, 2'd1, 16'h0005, 8'd0, 1'b0);
    checkOutput("held_first_accept", 32'(hs), 32'd1);
    acceptIdx = -1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'd2, 16'h0, 8'd2, 1'b0);
      if (hs) begin
        acceptIdx = i;
        break;
      end
    end
    checkOutput("held_accept_cycle", 32'(acceptIdx), 32'd2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd0, 16'h0, 8'd0, 1'b0);
    checkOutput("held_final_shadow", 32'(SHADOW), 32'h0007);

    // Random commands with occasional mid-command resets
    for (int i = 0; i < 1500; i++) begin
      rv  = ($urandom_range(0, 59) == 0);
      vv  = 1'($urandom_range(0, 1));
      opv = 2'($urandom_range(0, 3));
      nv  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      applyStimulus(vv, opv, WIDTH'($urandom), nv, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
